// File: rtl/crossing_if.sv
// Move-command channel between the crossing scheduler and the animator.
// Handshake: the master raises move_valid with move_who/move_dir and holds all
// three stable until it samples move_valid & move_ready high on a rising clock
// edge; that edge is the transfer. move_done is a single-cycle pulse from the
// animator when the accepted move has finished playing.
interface crossing_if;
    logic       move_valid;
    logic [1:0] move_who;
    logic       move_dir;
    logic       move_ready;
    logic       move_done;

    modport master (
        output move_valid,
        output move_who,
        output move_dir,
        input  move_ready,
        input  move_done
    );

    modport slave (
        input  move_valid,
        input  move_who,
        input  move_dir,
        output move_ready,
        output move_done
    );
endinterface

// File: rtl/crossing_sched.sv
// River-crossing puzzle scheduler: turns button edges into canoe moves,
// tracks bank positions, and decides win/lose after every completed move.
// Optional feature macro: CROSSING_TIMEOUT_EN adds an animator watchdog that
// aborts a move after TIMEOUT_TICKS step_tick strobes in BUSY.
module crossing_sched #(
    parameter int TIMEOUT_TICKS = 24
) (
    input  logic        clk_1kHz,
    input  logic        rst,
    input  logic        sw6,
    input  logic        step_tick,
    input  logic [3:0]  req,
    crossing_if.master  mv,
    output logic        cat_pos,
    output logic        dog_pos,
    output logic        mouse_pos,
    output logic        canoe_pos,
    output logic [1:0]  game_state,
    output logic [3:0]  reject_cnt,
    output logic        timeout,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_CHECK = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    localparam logic [1:0] GS_LOSE = 2'd0;
    localparam logic [1:0] GS_WIN  = 2'd1;
    localparam logic [1:0] GS_PLAY = 2'd2;

    state_t     state;
    logic [3:0] req_q;
    logic [3:0] edge_vec;
    logic       any_edge;
    logic [1:0] win_who;
    logic       win_legal;
    logic       lose_now;

    assign fsm_state = state;
    assign edge_vec  = req & ~req_q;
    assign any_edge  = |edge_vec;
    // Dog or mouse left with the cat on the bank the canoe just departed.
    assign lose_now  = ((cat_pos == dog_pos) && (cat_pos != canoe_pos)) ||
                       ((cat_pos == mouse_pos) && (cat_pos != canoe_pos));

`ifdef CROSSING_TIMEOUT_EN
    localparam int         CW   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_TICKS - 1);
    logic [CW-1:0] tick_cnt;
    logic          timeout_q;
    assign timeout = timeout_q;
`else
    logic unused_tick;
    assign unused_tick = step_tick & (TIMEOUT_TICKS > 0);
    assign timeout     = 1'b0;
`endif

    // Pick the highest-priority new edge and decide whether it can sail now.
    always_comb begin
        win_who   = 2'd3;
        win_legal = 1'b1;
        if (edge_vec[3]) begin
            win_who   = 2'd0;
            win_legal = (cat_pos == canoe_pos);
        end else if (edge_vec[2]) begin
            win_who   = 2'd1;
            win_legal = (dog_pos == canoe_pos);
        end else if (edge_vec[1]) begin
            win_who   = 2'd2;
            win_legal = (mouse_pos == canoe_pos);
        end
    end

    // Previous button levels, used only for rising-edge detection.
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) req_q <= 4'd0;
        else     req_q <= req;
    end

    // Game controller: request arbitration, move handshake, position update, verdict.
    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            mv.move_valid <= 1'b0;
            mv.move_who   <= 2'd0;
            mv.move_dir   <= 1'b0;
            cat_pos       <= 1'b0;
            dog_pos       <= 1'b0;
            mouse_pos     <= 1'b0;
            canoe_pos     <= 1'b0;
            game_state    <= GS_PLAY;
            reject_cnt    <= 4'd0;
`ifdef CROSSING_TIMEOUT_EN
            tick_cnt      <= '0;
            timeout_q     <= 1'b0;
`endif
        end else if (!sw6 && (state == S_IDLE || state == S_WIN || state == S_LOSE)) begin
            // Game switched off while settled: wipe the board.
            state      <= S_IDLE;
            cat_pos    <= 1'b0;
            dog_pos    <= 1'b0;
            mouse_pos  <= 1'b0;
            canoe_pos  <= 1'b0;
            game_state <= GS_PLAY;
            reject_cnt <= 4'd0;
`ifdef CROSSING_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_edge) begin
                        if (win_legal) begin
                            mv.move_valid <= 1'b1;
                            mv.move_who   <= win_who;
                            mv.move_dir   <= canoe_pos;
                            state         <= S_ISSUE;
                        end else if (reject_cnt != 4'hF) begin
                            reject_cnt <= reject_cnt + 4'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mv.move_ready) begin
                        mv.move_valid <= 1'b0;
                        state         <= S_BUSY;
`ifdef CROSSING_TIMEOUT_EN
                        tick_cnt      <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    if (mv.move_done) begin
                        canoe_pos <= ~canoe_pos;
                        case (mv.move_who)
                            2'd0:    cat_pos   <= ~cat_pos;
                            2'd1:    dog_pos   <= ~dog_pos;
                            2'd2:    mouse_pos <= ~mouse_pos;
                            default: ;
                        endcase
                        state <= S_CHECK;
                    end
`ifdef CROSSING_TIMEOUT_EN
                    else if (step_tick) begin
                        if (tick_cnt == TMAX) begin
                            state     <= S_IDLE;
                            timeout_q <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_CHECK: begin
                    if (cat_pos && dog_pos && mouse_pos) begin
                        state      <= S_WIN;
                        game_state <= GS_WIN;
                    end else if (lose_now) begin
                        state      <= S_LOSE;
                        game_state <= GS_LOSE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WIN, S_LOSE: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crossing_sched.sv
// Directed bench for crossing_sched: reset values, single moves, full winning
// game, rejection counting, priority, handshake stall, sw6 mid-move, watchdog
// (or its absence) and reset mid-move.
module tb_crossing_sched;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BUSY = 3'd2;
    localparam logic [2:0] ST_WIN  = 3'd4;
    localparam logic [2:0] ST_LOSE = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw6;
    logic       step_tick;
    logic [3:0] req;
    logic       cat_pos, dog_pos, mouse_pos, canoe_pos;
    logic [1:0] game_state;
    logic [3:0] reject_cnt;
    logic       timeout;
    logic [2:0] fsm_state;

    int checks   = 0;
    int failures = 0;

    crossing_if mv_if ();

    crossing_sched #(.TIMEOUT_TICKS(24)) dut (
        .clk_1kHz  (clk),
        .rst       (rst),
        .sw6       (sw6),
        .step_tick (step_tick),
        .req       (req),
        .mv        (mv_if),
        .cat_pos   (cat_pos),
        .dog_pos   (dog_pos),
        .mouse_pos (mouse_pos),
        .canoe_pos (canoe_pos),
        .game_state(game_state),
        .reject_cnt(reject_cnt),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the given buttons for one cycle, then release.
    task automatic press(input logic [3:0] bits);
        req = bits;
        cyc(1);
        req = 4'd0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (mv_if.move_valid !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        check("wait_valid", 32'(mv_if.move_valid), 32'd1);
    endtask

    task automatic accept();
        mv_if.move_ready = 1'b1;
        cyc(1);
        mv_if.move_ready = 1'b0;
    endtask

    // Wait, pulse move_done, then let CHECK resolve.
    task automatic finish_move(input int delay);
        cyc(delay);
        mv_if.move_done = 1'b1;
        cyc(1);
        mv_if.move_done = 1'b0;
        cyc(1);
    endtask

    task automatic do_move(input logic [3:0] bits);
        press(bits);
        wait_valid();
        accept();
        finish_move(2);
    endtask

    task automatic clear_game();
        sw6 = 1'b0;
        cyc(1);
        sw6 = 1'b1;
        cyc(1);
    endtask

    initial begin
        rst = 1'b0; sw6 = 1'b0; step_tick = 1'b0; req = 4'd0;
        mv_if.move_ready = 1'b0; mv_if.move_done = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", 32'(mv_if.move_valid), 32'd0);
        check("rst_who",   32'(mv_if.move_who), 32'd0);
        check("rst_dir",   32'(mv_if.move_dir), 32'd0);
        check("rst_pos",   32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'd0);
        check("rst_gs",    32'(game_state), 32'd2);
        check("rst_rej",   32'(reject_cnt), 32'd0);
        check("rst_to",    32'(timeout), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        cyc(2);
        rst = 1'b0;
        sw6 = 1'b1;
        cyc(1);

        // Canoe crosses alone: animals stranded together on the left -> lose.
        press(4'b0001);
        check("c1_valid", 32'(mv_if.move_valid), 32'd1);
        check("c1_who",   32'(mv_if.move_who), 32'd3);
        check("c1_dir",   32'(mv_if.move_dir), 32'd0);
        accept();
        check("c1_acc_valid", 32'(mv_if.move_valid), 32'd0);
        check("c1_busy",      32'(fsm_state), 32'(ST_BUSY));
        finish_move(5);
        check("c1_canoe", 32'(canoe_pos), 32'd1);
        check("c1_gs",    32'(game_state), 32'd0);
        check("c1_lose",  32'(fsm_state), 32'(ST_LOSE));
        press(4'b1000);
        check("lose_ignores", 32'(mv_if.move_valid), 32'd0);
        sw6 = 1'b0;
        cyc(1);
        check("off_pos",   32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'd0);
        check("off_gs",    32'(game_state), 32'd2);
        check("off_state", 32'(fsm_state), 32'(ST_IDLE));
        sw6 = 1'b1;
        cyc(1);

        // Winning sequence.
        do_move(4'b1000);
        do_move(4'b0001);
        do_move(4'b0100);
        do_move(4'b1000);
        do_move(4'b0010);
        do_move(4'b0001);
        do_move(4'b1000);
        check("win_pos",   32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'hF);
        check("win_gs",    32'(game_state), 32'd1);
        check("win_state", 32'(fsm_state), 32'(ST_WIN));
        cyc(3);
        check("win_hold",  32'(game_state), 32'd1);
        clear_game();

        // Cat over, then a stray done in IDLE, then illegal dog requests.
        do_move(4'b1000);
        check("cat_over", 32'({cat_pos, canoe_pos}), 32'h3);
        mv_if.move_done = 1'b1;
        cyc(1);
        mv_if.move_done = 1'b0;
        cyc(1);
        check("stray_done", 32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'b1001);
        press(4'b0100);
        check("rej_valid", 32'(mv_if.move_valid), 32'd0);
        check("rej_one",   32'(reject_cnt), 32'd1);
        cyc(1);
        for (int i = 0; i < 16; i++) begin
            press(4'b0100);
            cyc(1);
        end
        check("rej_sat", 32'(reject_cnt), 32'd15);

        // Cat and mouse together: cat wins, mouse edge dropped uncounted.
        press(4'b1010);
        check("pri_valid", 32'(mv_if.move_valid), 32'd1);
        check("pri_who",   32'(mv_if.move_who), 32'd0);
        check("pri_dir",   32'(mv_if.move_dir), 32'd1);
        check("pri_rej",   32'(reject_cnt), 32'd15);
        accept();
        press(4'b0010);
        cyc(1);
        check("busy_edge_valid", 32'(mv_if.move_valid), 32'd0);
        check("busy_edge_state", 32'(fsm_state), 32'(ST_BUSY));
        finish_move(1);
        check("back_pos",   32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'd0);
        check("back_state", 32'(fsm_state), 32'(ST_IDLE));
        check("back_valid", 32'(mv_if.move_valid), 32'd0);

        // Stalled handshake: dog command held steady until ready.
        press(4'b0100);
        for (int i = 0; i < 10; i++) begin
            check("stall_cmd", 32'({mv_if.move_valid, mv_if.move_who, mv_if.move_dir}), 32'b1010);
            cyc(1);
        end
        accept();
        check("stall_acc", 32'(mv_if.move_valid), 32'd0);
        finish_move(3);
        check("dog_pos",  32'(dog_pos), 32'd1);
        check("dog_lose", 32'(game_state), 32'd0);
        clear_game();

        // sw6 dropped mid-move: move lands, verdict given, then board wiped.
        press(4'b0010);
        wait_valid();
        accept();
        sw6 = 1'b0;
        finish_move(2);
        check("mid_pos",   32'({mouse_pos, canoe_pos}), 32'h3);
        check("mid_gs",    32'(game_state), 32'd0);
        check("mid_state", 32'(fsm_state), 32'(ST_LOSE));
        cyc(1);
        check("mid_clear_pos", 32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'd0);
        check("mid_clear_gs",  32'(game_state), 32'd2);
        sw6 = 1'b1;
        cyc(1);

        // Animator never finishes.
        press(4'b1000);
        wait_valid();
        accept();
        for (int i = 0; i < 23; i++) begin
            step_tick = 1'b1;
            cyc(1);
            step_tick = 1'b0;
            cyc(1);
        end
        check("to_pre_state", 32'(fsm_state), 32'(ST_BUSY));
        check("to_pre_flag",  32'(timeout), 32'd0);
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        cyc(1);
`ifdef CROSSING_TIMEOUT_EN
        check("to_state", 32'(fsm_state), 32'(ST_IDLE));
        check("to_flag",  32'(timeout), 32'd1);
        check("to_pos",   32'({cat_pos, canoe_pos}), 32'd0);
        cyc(3);
        check("to_sticky", 32'(timeout), 32'd1);
`else
        check("nto_state", 32'(fsm_state), 32'(ST_BUSY));
        check("nto_flag",  32'(timeout), 32'd0);
`endif
        rst = 1'b1;
        #1;
        check("rst2_to",    32'(timeout), 32'd0);
        check("rst2_state", 32'(fsm_state), 32'(ST_IDLE));
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // Reset in the middle of a move discards it.
        press(4'b1000);
        wait_valid();
        accept();
        cyc(2);
        check("mid_busy", 32'(fsm_state), 32'(ST_BUSY));
        rst = 1'b1;
        #1;
        check("rstb_pos",   32'({cat_pos, dog_pos, mouse_pos, canoe_pos}), 32'd0);
        check("rstb_state", 32'(fsm_state), 32'(ST_IDLE));
        check("rstb_valid", 32'(mv_if.move_valid), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        finish_move(1);
        check("rstb_late_done", 32'({cat_pos, canoe_pos}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossing_sched.md
CROSSING_SCHED -- requirements
Module: crossing_sched

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 24: step_tick count allowed in BUSY before abort (only with CROSSING_TIMEOUT_EN).
REQ-002 clk_1kHz  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sw6  input  1  game enable; 0 = game off.
REQ-005 step_tick  input  1  one-cycle strobe at 4 Hz rate (timeout base).
REQ-006 req  input  4  debounced button levels; [3] cat, [2] dog, [1] mouse, [0] canoe.
REQ-007 move_valid  output  1  move command offered to animator.
REQ-008 move_who  output  2  0 cat, 1 dog, 2 mouse, 3 canoe alone.
REQ-009 move_dir  output  1  0 left->right, 1 right->left.
REQ-010 move_ready  input  1  animator accepts command.
REQ-011 move_done  input  1  one-cycle pulse, animation finished.
REQ-012 cat_pos, dog_pos, mouse_pos, canoe_pos  output  1 each  0 left bank, 1 right bank.
REQ-013 game_state  output  2  0 lose, 1 win, 2 playing.
REQ-014 reject_cnt  output  4  illegal request count, saturating.
REQ-015 timeout  output  1  sticky animator-timeout flag.

Function
REQ-016 FSM states IDLE, ISSUE, BUSY, CHECK, WIN, LOSE.
REQ-017 Requests are rising edges of req (registered req_q); levels alone never start a move.
REQ-018 IDLE, sw6=1, any edge: highest-priority edge wins (cat>dog>mouse>canoe); lower simultaneous edges dropped, not counted.
REQ-019 Winner legal if canoe, or animal pos == canoe_pos; legal -> ISSUE next cycle, load move_who, move_dir=canoe_pos.
REQ-020 Winner illegal -> stay IDLE, reject_cnt+1, saturate at 15.
REQ-021 Edges in any state other than IDLE ignored, not counted.
REQ-022 ISSUE: move_valid=1, move_who/move_dir stable until move_valid&move_ready; accept -> BUSY next cycle, move_valid=0.
REQ-023 BUSY: on move_done, canoe_pos toggles; moved animal pos toggles (none if who=3); -> CHECK.
REQ-024 move_done outside BUSY ignored.
REQ-025 CHECK (1 cycle): all three animals =1 -> WIN; else (cat==dog && cat!=canoe) or (cat==mouse && cat!=canoe) -> LOSE; else IDLE.
REQ-026 game_state: 1 in WIN, 0 in LOSE, 2 otherwise.
REQ-027 sw6=0 in IDLE/WIN/LOSE: next cycle all positions 0, reject_cnt 0, timeout 0, state IDLE.
REQ-028 sw6=0 in ISSUE/BUSY/CHECK: in-flight move completes normally; REQ-027 applies on return to IDLE/WIN/LOSE.
REQ-029 WIN/LOSE exit only via sw6=0 or rst.

Reset
REQ-030 rst=1 immediately forces IDLE, move_valid 0, move_who 0, move_dir 0, all pos 0, game_state 2, reject_cnt 0, timeout 0, req_q 0.
REQ-031 rst mid-BUSY discards the move; positions stay 0.

Configuration
REQ-032 Macro CROSSING_TIMEOUT_EN defined: BUSY counts step_tick; at TIMEOUT_TICKS without move_done -> IDLE, positions unchanged, timeout=1 sticky; counter clears on BUSY entry.
REQ-033 Macro undefined: no counter, BUSY waits indefinitely, timeout tied 0.

Verification
REQ-034 rst, sw6=1, req[0] edge, ready=1, done after 5 cycles -> who=3, dir=0, canoe_pos=1, game_state=0.
REQ-035 Moves cat, canoe, dog, cat, mouse, canoe, cat (each ready+done) -> all pos=1, game_state=1.
REQ-036 After cat move (canoe=1), req[2] edge -> no move_valid, reject_cnt=1; 16 more illegal edges -> reject_cnt=15.
REQ-037 req[3] and req[1] edges same cycle -> who=0 only; req[1] edge during BUSY -> no second command.
REQ-038 move_ready held 0 for 10 cycles -> move_valid, who, dir stable throughout; accept on first ready.
REQ-039 CROSSING_TIMEOUT_EN, TIMEOUT_TICKS=24, no move_done, 24 step_ticks -> IDLE, timeout=1, positions unchanged; undefined -> stays BUSY.
